// File: rtl/audio_in_rx_if.sv
// Codec-side capture bus for the WM8731 ADC receiver: codec clocks/data in,
// coherent stereo samples and status out.
interface audio_in_rx_if #(
  parameter int DATA_W = 16
);
  logic              en;
  logic              bclk;
  logic              adclrc;
  logic              adcdat;
  logic [DATA_W-1:0] left_data;
  logic [DATA_W-1:0] right_data;
  logic              sample_valid;
  logic              frame_err;
  logic              locked;

  modport master (
    output en, bclk, adclrc, adcdat,
    input  left_data, right_data, sample_valid, frame_err, locked
  );

  modport slave (
    input  en, bclk, adclrc, adcdat,
    output left_data, right_data, sample_valid, frame_err, locked
  );
endinterface

// File: rtl/audio_in_rx.sv
// WM8731 ADC-path receiver: oversamples codec BCLK/ADCLRC with clk_50m and
// deserialises right-justified ADCDAT into coherent left/right sample pairs.
module audio_in_rx #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic          clk_50m,
  input  logic          rst,
  audio_in_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  state_t            state, state_next;
  logic              bclk_s1, bclk_s2, bclk_s3;
  logic              lrc_s1, lrc_s2, lrc_s3;
  logic              dat_s1, dat_s2;
  logic [1:0]        settle;
  logic              b_rise, lrc_rise, lrc_fall, lrc_edge;
  logic [DATA_W-1:0] shreg, shreg_next, left_hold, left_q, right_q;
  logic [CNT_W-1:0]  bitcnt, cnt_next;
  logic              valid_q, err_q;
  logic              cap_left, cap_pair, short_half;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      bclk_s1 <= 1'b0; bclk_s2 <= 1'b0; bclk_s3 <= 1'b0;
      lrc_s1  <= 1'b0; lrc_s2  <= 1'b0; lrc_s3  <= 1'b0;
      dat_s1  <= 1'b0; dat_s2  <= 1'b0;
    end else begin
      bclk_s1 <= bus.bclk;   bclk_s2 <= bclk_s1; bclk_s3 <= bclk_s2;
      lrc_s1  <= bus.adclrc; lrc_s2  <= lrc_s1;  lrc_s3  <= lrc_s2;
      dat_s1  <= bus.adcdat; dat_s2  <= dat_s1;
    end
  end

  // Synchroniser flops restart at 0 after reset; holding IDLE until they have
  // refilled stops a high ADCLRC from looking like a fresh rising edge.
  always_ff @(posedge clk_50m) begin
    if (rst)
      settle <= '0;
    else if (settle != 2'd3)
      settle <= settle + 2'd1;
  end

  always_comb begin
    b_rise     = bclk_s2 & ~bclk_s3;
    lrc_rise   = lrc_s2 & ~lrc_s3;
    lrc_fall   = ~lrc_s2 & lrc_s3;
    lrc_edge   = lrc_rise | lrc_fall;
    shreg_next = b_rise ? {shreg[DATA_W-2:0], dat_s2} : shreg;
    cnt_next   = (b_rise && bitcnt != CNT_MAX) ? bitcnt + 1'b1 : bitcnt;
  end

  always_ff @(posedge clk_50m) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cap_left   = 1'b0;
    cap_pair   = 1'b0;
    short_half = 1'b0;
    if (!bus.en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (settle == 2'd3) state_next = SYNC;
        SYNC: if (lrc_rise) state_next = RUN;
        RUN: begin
          cap_left   = lrc_fall;
          cap_pair   = lrc_rise;
          short_half = lrc_edge && (cnt_next < CNT_FULL);
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A bit arriving in the same cycle as the LRC edge belongs to the ended
  // half, so the latches take shreg_next and the count restarts at zero.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      shreg     <= '0;
      bitcnt    <= '0;
      left_hold <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shreg   <= shreg_next;
      bitcnt  <= lrc_edge ? '0 : cnt_next;
      valid_q <= cap_pair;
      err_q   <= short_half;
      if (cap_left)
        left_hold <= shreg_next;
      if (cap_pair) begin
        right_q <= shreg_next;
        left_q  <= left_hold;
      end
    end
  end

  assign bus.left_data    = left_q;
  assign bus.right_data   = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;
  assign bus.locked       = (state == RUN);

endmodule

// File: tb/tb_audio_in_rx.sv
// Bench for audio_in_rx: codec-style serial stimulus with a frame-level model
// of expected sample pairs and short-half errors.
module tb_audio_in_rx;
  localparam int DATA_W = 16;

  logic clk_50m = 1'b0;
  logic rst = 1'b1;
  always #10 clk_50m = ~clk_50m;

  audio_in_rx_if #(.DATA_W(DATA_W)) bus ();

  audio_in_rx #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int valid_seen = 0;
  int err_seen   = 0;

  // Frame-level model: last DATA_W bits seen on BCLK rises, pending pairs/errors.
  logic [15:0] hist = '0;
  logic [15:0] left_hold_m = '0;
  logic [15:0] cur_l = '0;
  logic [15:0] cur_r = '0;
  logic [31:0] exp_q[$];
  int          m_errs = 0;
  bit          m_synced = 1'b0;
  int          half_bits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_50m) begin
    #1;
    if (bus.sample_valid === 1'b1) begin
      valid_seen++;
      check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        {cur_l, cur_r} = exp_q.pop_front();
    end
    if (bus.frame_err === 1'b1) begin
      err_seen++;
      check("err_expected", 32'(m_errs > 0), 32'd1);
      if (m_errs > 0)
        m_errs--;
    end
    check("left_data", 32'(bus.left_data), 32'(cur_l));
    check("right_data", 32'(bus.right_data), 32'(cur_r));
  end

  task automatic model_edge(input logic rising, input int nb);
    if (!bus.en)
      return;
    if (!m_synced) begin
      if (rising)
        m_synced = 1'b1;
      return;
    end
    if (nb < DATA_W)
      m_errs++;
    if (!rising)
      left_hold_m = hist;
    else
      exp_q.push_back({left_hold_m, hist});
  endtask

  task automatic toggle_lrc();
    bus.adclrc = ~bus.adclrc;
    model_edge(bus.adclrc, half_bits);
    half_bits = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hist = '0;
    left_hold_m = '0;
    cur_l = '0;
    cur_r = '0;
    m_synced = 1'b0;
    half_bits = 0;
    repeat (2) @(negedge clk_50m);
    rst = 1'b0;
  endtask

  // action: 0 none, 1 raise en at mid-half, 2 reset pulse at mid-half
  task automatic send_half(input logic [31:0] word, input int nbits, input int hp,
                           input bit coinc, input int action);
    for (int i = 0; i < nbits; i++) begin
      bus.adcdat = word[nbits-1-i];
      if (i == nbits / 2) begin
        check("locked", 32'(bus.locked), 32'(m_synced & bus.en));
        if (action == 1) bus.en = 1'b1;
        if (action == 2) do_reset();
      end
      repeat (hp) @(negedge clk_50m);
      bus.bclk = 1'b1;
      hist = {hist[14:0], bus.adcdat};
      half_bits++;
      if (coinc && i == nbits - 1)
        toggle_lrc();
      repeat (hp) @(negedge clk_50m);
      bus.bclk = 1'b0;
    end
    if (!coinc)
      toggle_lrc();
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl,
                            input int nr, input int hp, input bit coinc);
    send_half({16'($urandom), l}, nl, hp, coinc, 0);
    send_half({16'($urandom), r}, nr, hp, coinc, 0);
  endtask

  int v0;

  initial begin
    bus.en = 1'b0; bus.bclk = 1'b0; bus.adclrc = 1'b0; bus.adcdat = 1'b0;
    repeat (4) @(negedge clk_50m);
    check("reset_left", 32'(bus.left_data), 32'h0);
    check("reset_right", 32'(bus.right_data), 32'h0);
    check("reset_valid", 32'(bus.sample_valid), 32'h0);
    check("reset_err", 32'(bus.frame_err), 32'h0);
    check("reset_locked", 32'(bus.locked), 32'h0);
    rst = 1'b0;
    bus.en = 1'b1;
    repeat (6) @(negedge clk_50m);

    // 64fs, BCLK = 16 clk: prime with a right half, then two full frames
    send_half($urandom, 32, 8, 1'b0, 0);
    repeat (2) send_frame(16'h1234, 16'hA5C3, 32, 32, 8, 1'b0);
    repeat (8) @(negedge clk_50m);
    check("t1_left", 32'(bus.left_data), 32'h1234);
    check("t1_right", 32'(bus.right_data), 32'hA5C3);
    check("t1_valid_count", 32'(valid_seen), 32'd2);
    check("t1_err_count", 32'(err_seen), 32'd0);
    check("t1_locked", 32'(bus.locked), 32'd1);

    send_frame(16'h8000, 16'h7FFF, 32, 32, 8, 1'b0);
    repeat (8) @(negedge clk_50m);
    check("t2a_left", 32'(bus.left_data), 32'h8000);
    check("t2a_right", 32'(bus.right_data), 32'h7FFF);
    send_frame(16'h0001, 16'hFFFF, 32, 32, 8, 1'b0);
    repeat (8) @(negedge clk_50m);
    check("t2b_left", 32'(bus.left_data), 32'h0001);
    check("t2b_right", 32'(bus.right_data), 32'hFFFF);
    check("t2_valid_count", 32'(valid_seen), 32'd4);

    // 12-bit left half: upper nibble still holds the tail of the 0xFFFF right sample
    send_half(32'h0000_0ABC, 12, 8, 1'b0, 0);
    send_half({16'($urandom), 16'h5A5A}, 32, 8, 1'b0, 0);
    repeat (8) @(negedge clk_50m);
    check("t4_err_count", 32'(err_seen), 32'd1);
    check("t4_left", 32'(bus.left_data), 32'hFABC);
    check("t4_right", 32'(bus.right_data), 32'h5A5A);

    // enable arrives mid left half
    bus.en = 1'b0;
    m_synced = 1'b0;
    repeat (4) @(negedge clk_50m);
    check("t3_unlocked", 32'(bus.locked), 32'd0);
    v0 = valid_seen;
    send_half($urandom, 32, 8, 1'b0, 1);
    send_half($urandom, 32, 8, 1'b0, 0);
    repeat (8) @(negedge clk_50m);
    check("t3_no_pulse", 32'(valid_seen), 32'(v0));
    check("t3_locked", 32'(bus.locked), 32'd1);
    send_frame(16'h3C3C, 16'hC3C3, 32, 32, 8, 1'b0);
    repeat (8) @(negedge clk_50m);
    check("t3_valid_count", 32'(valid_seen), 32'(v0 + 1));
    check("t3_left", 32'(bus.left_data), 32'h3C3C);

    // reset mid left half
    v0 = valid_seen;
    send_half($urandom, 32, 8, 1'b0, 2);
    send_half($urandom, 32, 8, 1'b0, 0);
    repeat (8) @(negedge clk_50m);
    check("t5_no_pulse", 32'(valid_seen), 32'(v0));
    check("t5_left_zero", 32'(bus.left_data), 32'h0);
    check("t5_right_zero", 32'(bus.right_data), 32'h0);
    send_frame(16'h2468, 16'h1357, 32, 32, 8, 1'b0);
    repeat (8) @(negedge clk_50m);
    check("t5_left", 32'(bus.left_data), 32'h2468);
    check("t5_right", 32'(bus.right_data), 32'h1357);

    // BCLK = 6 clk, LRC toggles together with the last BCLK rise
    v0 = err_seen;
    repeat (2) send_frame(16'($urandom), 16'($urandom), 16, 16, 3, 1'b1);
    send_frame(16'h8001, 16'h7FFE, 16, 16, 3, 1'b1);
    repeat (8) @(negedge clk_50m);
    check("t6_left", 32'(bus.left_data), 32'h8001);
    check("t6_right", 32'(bus.right_data), 32'h7FFE);
    check("t6_no_err", 32'(err_seen), 32'(v0));

    for (int k = 0; k < 10; k++)
      send_frame(16'($urandom), 16'($urandom), $urandom_range(32, 14),
                 $urandom_range(32, 14), $urandom_range(8, 3), 1'($urandom_range(1, 0)));

    repeat (10) @(negedge clk_50m);
    check("pending_pairs", 32'(exp_q.size()), 32'd0);
    check("pending_errs", 32'(m_errs), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
